// File: rtl/sbox_word_sequencer.sv
// Feeds the four bytes of a word through a shared, pipelined S-box one per cycle and
// reassembles the returned bytes into a 32-bit result.
module sbox_word_sequencer #(
    parameter int unsigned SBOX_LAT = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    input  logic        in_decrypt,
    output logic [7:0]  sbox_x,
    output logic        sbox_decrypt,
    input  logic [7:0]  sbox_w,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic        busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        in_ready_q;
    logic [31:0] word_q;
    logic        dec_q;
    logic [1:0]  idx_q;
    logic [31:0] out_word_q, out_word_d;
    logic        accept;
    logic        issue;
    logic        cap_valid;
    logic [1:0]  cap_idx;

    assign accept = (state_q == IDLE) && in_valid && in_ready_q;
    assign issue  = (state_q == ISSUE);

    // Tag each issued byte with its index so the result lands in the right lane.
    generate
        if (SBOX_LAT == 0) begin : g_comb
            assign cap_valid = issue;
            assign cap_idx   = idx_q;
        end else begin : g_pipe
            logic [SBOX_LAT-1:0] vld_q;
            logic [1:0]          tag_q [SBOX_LAT];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    vld_q <= '0;
                    for (int i = 0; i < int'(SBOX_LAT); i++) tag_q[i] <= 2'd0;
                end else begin
                    vld_q[0] <= issue;
                    tag_q[0] <= idx_q;
                    for (int i = 1; i < int'(SBOX_LAT); i++) begin
                        vld_q[i] <= vld_q[i-1];
                        tag_q[i] <= tag_q[i-1];
                    end
                end
            end

            assign cap_valid = vld_q[SBOX_LAT-1];
            assign cap_idx   = tag_q[SBOX_LAT-1];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   if (idx_q == 2'd3) state_d = (SBOX_LAT == 0) ? DONE : DRAIN;
            DRAIN:   if (cap_valid && (cap_idx == 2'd3)) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_word_d = out_word_q;
        if (cap_valid) begin
            unique case (cap_idx)
                2'd0: out_word_d[31:24] = sbox_w;
                2'd1: out_word_d[23:16] = sbox_w;
                2'd2: out_word_d[15:8]  = sbox_w;
                2'd3: out_word_d[7:0]   = sbox_w;
                default: out_word_d = out_word_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
            word_q     <= 32'd0;
            dec_q      <= 1'b0;
            idx_q      <= 2'd0;
            out_word_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            // Only ready once settled in IDLE, so a word is never taken on the DONE exit edge.
            in_ready_q <= (state_d == IDLE);
            out_word_q <= out_word_d;
            if (accept) begin
                word_q <= in_word;
                dec_q  <= in_decrypt;
                idx_q  <= 2'd0;
            end else if (issue) begin
                idx_q  <= idx_q + 2'd1;
            end
        end
    end

    // Hold the S-box input at zero between issues to limit toggling.
    always_comb begin
        sbox_x = 8'd0;
        if (issue) begin
            unique case (idx_q)
                2'd0: sbox_x = word_q[31:24];
                2'd1: sbox_x = word_q[23:16];
                2'd2: sbox_x = word_q[15:8];
                2'd3: sbox_x = word_q[7:0];
                default: sbox_x = 8'd0;
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign busy         = (state_q != IDLE);
    assign out_valid    = (state_q == DONE);
    assign out_word     = out_word_q;
    assign sbox_decrypt = busy && dec_q;

endmodule
